// File: rtl/sugar_spawner.sv
// Sugar source for the ant map: picks pseudo-random cells and drives placeSugar for the granted one.
// Optional SUGAR_SKIP_OCCUPIED_EN adds an occupied-cell check with retries and a drop pulse.
module sugar_spawner #(
   parameter int          X_BITS    = 8,
   parameter int          Y_BITS    = 8,
   parameter int          PERIOD    = 1000,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          MAX_TRIES = 4
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       enable,
   input  logic                       manual,
   input  logic                       grant,
   input  logic                       curSugar,
   output logic                       req,
   output logic [X_BITS+Y_BITS-1:0]   reqLoc,
   output logic                       placeSugar,
   output logic                       drop,
   output logic [15:0]                placed_count
);

   localparam int          LOC_BITS  = X_BITS + Y_BITS;
   localparam int          CNT_BITS  = $clog2(PERIOD);
   localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

   typedef enum logic [2:0] {
      IDLE,
      PICK,
      REQ,
      READ,
      WRITE
   } spawnState_t;

   spawnState_t          state;
   logic [CNT_BITS-1:0]  periodCnt;
   logic                 pending;
   logic [15:0]          lfsr;
   logic                 trigger;
   logic                 feedback;

`ifdef SUGAR_SKIP_OCCUPIED_EN
   localparam int TRY_BITS = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   logic [TRY_BITS-1:0]  tries;
`else
   logic                 unusedCurSugar;
   assign unusedCurSugar = curSugar;
`endif

   assign trigger  = enable && (periodCnt == CNT_BITS'(PERIOD - 1));
   assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Free-running spawn timer; freezes while disabled without disturbing a spawn in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         periodCnt <= '0;
      end else if (enable) begin
         if (trigger) periodCnt <= '0;
         else         periodCnt <= periodCnt + CNT_BITS'(1);
      end
   end

   // Spawn sequencer: one queued request at most, LFSR advances only when a cell is picked.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         pending      <= 1'b0;
         lfsr         <= LFSR_INIT;
         req          <= 1'b0;
         reqLoc       <= '0;
         placeSugar   <= 1'b0;
         drop         <= 1'b0;
         placed_count <= 16'd0;
`ifdef SUGAR_SKIP_OCCUPIED_EN
         tries        <= '0;
`endif
      end else begin
         placeSugar <= 1'b0;
         drop       <= 1'b0;
         if (state != IDLE && (trigger || manual)) pending <= 1'b1;
         case (state)
            IDLE: begin
               if (trigger || manual || pending) begin
                  state   <= PICK;
                  pending <= 1'b0;
               end
            end
            PICK: begin
               reqLoc <= {lfsr[LOC_BITS-1:X_BITS], lfsr[X_BITS-1:0]};
               lfsr   <= {lfsr[14:0], feedback};
               req    <= 1'b1;
               state  <= REQ;
            end
            REQ: begin
               if (grant) begin
                  req <= 1'b0;
`ifdef SUGAR_SKIP_OCCUPIED_EN
                  state <= READ;
`else
                  placeSugar <= 1'b1;
                  state      <= WRITE;
`endif
               end
            end
`ifdef SUGAR_SKIP_OCCUPIED_EN
            READ: begin
               if (!curSugar) begin
                  placeSugar <= 1'b1;
                  state      <= WRITE;
               end else if (tries == TRY_BITS'(MAX_TRIES - 1)) begin
                  drop  <= 1'b1;
                  tries <= '0;
                  state <= IDLE;
               end else begin
                  tries <= tries + TRY_BITS'(1);
                  state <= PICK;
               end
            end
`endif
            WRITE: begin
               if (placed_count != 16'hFFFF) placed_count <= placed_count + 16'd1;
`ifdef SUGAR_SKIP_OCCUPIED_EN
               tries <= '0;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
